ll_stream_rr_scheduler: RTL and testbench
=========================================

Name: ll_stream_rr_scheduler

Overview:
- Round-robin scheduler that shares one single-token pass-through actor port (In1/Out1 token handshake) among NUM_SRC upstream pixel streams.
- Grants one source at a time for an atomic burst of BURST_LEN tokens, normally one image line, so lines from different sources never interleave.
- Forwards each token to the shared output and tags it with the source index.
- Sits between the per-channel line buffers of the visual-saliency pyramid and the shared Laplacian-level actor.

Parameters:
- NUM_SRC, 4, number of input streams (2..4).
- DATA_W, 16, token width in bits.
- BURST_LEN, 512, tokens per grant (1..65535).
- CNT_W, 16, width of the burst counter and of the COUNT buses.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- In_DATA  in  NUM_SRC*DATA_W  source tokens; source i occupies bits [i*DATA_W +: DATA_W].
- In_SEND  in  NUM_SRC  source i has a token available.
- In_COUNT  in  NUM_SRC*CNT_W  tokens available per source; informational only, ignored.
- In_ACK  out  NUM_SRC  one-cycle consume strobe per source.
- Out_DATA  out  DATA_W  forwarded token.
- Out_SEND  out  1  output token valid strobe.
- Out_COUNT  out  CNT_W  constant 1 while Out_SEND is high, else 0.
- Out_TAG  out  2  index of the granted source, valid with Out_SEND.
- Out_RDY  in  1  downstream can accept a token this cycle.
- Out_ACK  in  1  downstream acknowledge; ignored (buffering is downstream).
- BUSY  out  1  high while a grant is held.

Behaviour:
- Reset: RESET is asynchronous and active-high; clock CLK.
  - State is IDLE, rr_ptr=0, grant=0, burst_cnt=0.
  - All outputs are 0 while RESET is high and in the cycle after release.
- States:
  - IDLE: no grant, BUSY=0, In_ACK=0, Out_SEND=0.
    - If any In_SEND bit is set at a clock edge, latch grant = first requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
    - Clear burst_cnt and go to XFER. Arbitration latency is 1 cycle; no token moves in the decision cycle.
  - XFER: BUSY=1.
    - fire = In_SEND[grant] & Out_RDY, combinational within the cycle.
    - When fire: In_ACK[grant]=1, Out_SEND=1, Out_DATA=In_DATA[grant], Out_TAG=grant, Out_COUNT=1, all in the same cycle.
    - A fire with burst_cnt==BURST_LEN-1 ends the burst: rr_ptr<=grant+1 mod NUM_SRC, state<=IDLE.
    - Otherwise each fire increments burst_cnt.
    - No fire: hold state, burst_cnt and grant; outputs 0.
- Atomicity: once granted, a source keeps the port until BURST_LEN tokens have moved, even if its In_SEND drops or other sources request. There is no timeout.
- Non-granted sources never see In_ACK. At most one In_ACK bit is high in any cycle.
- Fairness: the source that just finished has lowest priority in the next arbitration. With all sources continuously requesting, grants go 0,1,2,3,0,...
- Back-to-back bursts: there is always exactly one idle cycle (IDLE) between bursts. Maximum throughput is BURST_LEN/(BURST_LEN+1) tokens per cycle.
- BURST_LEN=1: every token re-arbitrates; each grant is followed by an IDLE cycle.
- Counter: burst_cnt is CNT_W-bit unsigned and never exceeds BURST_LEN-1; no wrap-around is reachable.
- Out_RDY low with In_SEND high: no ACK and no SEND; the token stays at the source. Out_RDY must not gate state other than fire.
- RESET asserted mid-burst: immediate abort; the partial burst is lost and not resumed. After reset, arbitration restarts from source 0.
- In_COUNT and Out_ACK have no effect on behaviour.

Test Plan:
- Reset release, all In_SEND=0, Out_RDY=1 -> BUSY, In_ACK, Out_SEND stay 0 for 20 cycles.
- BURST_LEN=4, only source 2 sends tokens 0x0010..0x0013 with Out_RDY=1:
  - 1 arbitration cycle, then 4 consecutive Out_SEND with data 0x0010..0x0013 and Out_TAG=2.
  - In_ACK=4'b0100 on each of those cycles; BUSY then drops.
- BURST_LEN=4, all 4 sources always sending -> tag sequence 0,0,0,0,1,1,1,1,2,...,3 then 0, with one idle cycle between bursts.
- During the source-1 burst, Out_RDY low for 3 cycles after the 2nd token:
  - No ACK or SEND in those cycles.
  - Burst resumes and totals exactly 4 tokens; source 3 requesting meanwhile is not granted.
- Granted source 0 drops In_SEND after 2 of 4 tokens while source 1 requests -> grant held; remaining 2 tokens from source 0 are forwarded when In_SEND returns.
- RESET pulsed after 2 tokens of a source-3 burst:
  - Outputs 0 immediately (asynchronous).
  - After release, next grant starts from source 0 with burst_cnt=0.

Source files
------------

// File: rtl/ll_stream_rr_scheduler.sv
// ll_stream_rr_scheduler: round-robin share of one token port among NUM_SRC
// streams. Each grant is an atomic BURST_LEN-token burst (one image line).
//
// Ports:
//   CLK, RESET            clock, async active-high reset
//   In_DATA/In_SEND       per-source token and availability
//   In_COUNT              per-source token count (ignored)
//   In_ACK                per-source consume strobe
//   Out_DATA/Out_SEND     forwarded token and valid strobe
//   Out_COUNT             1 while Out_SEND, else 0
//   Out_TAG               granted source index, valid with Out_SEND
//   Out_RDY               downstream can accept a token this cycle
//   Out_ACK               downstream acknowledge (ignored)
//   BUSY                  high while a grant is held
module ll_stream_rr_scheduler #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 512,
    parameter int CNT_W     = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_SRC*DATA_W-1:0] In_DATA,
    input  logic [NUM_SRC-1:0]        In_SEND,
    input  logic [NUM_SRC*CNT_W-1:0]  In_COUNT,
    output logic [NUM_SRC-1:0]        In_ACK,
    output logic [DATA_W-1:0]         Out_DATA,
    output logic                      Out_SEND,
    output logic [CNT_W-1:0]          Out_COUNT,
    output logic [1:0]                Out_TAG,
    input  logic                      Out_RDY,
    input  logic                      Out_ACK,
    output logic                      BUSY
);

    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t           state, state_nx;
    logic [1:0]       rr_ptr, rr_ptr_nx;
    logic [1:0]       grant, grant_nx;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nx;

    logic             any_req;
    logic [1:0]       pick;
    logic             req_g;
    logic [DATA_W-1:0] data_g;
    logic             fire;

    // The flow-control side channels carry no information this block needs.
    logic             unused_ok;
    assign unused_ok = ^{In_COUNT, Out_ACK};

    // First requester at or after rr_ptr; the descending scan lets the
    // smallest rotation distance win.
    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (In_SEND[i] && ((int'(rr_ptr) + k) % NUM_SRC) == i) begin
                    any_req = 1'b1;
                    pick    = 2'(i);
                end
            end
        end
    end

    always_comb begin
        req_g  = 1'b0;
        data_g = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == 2'(i)) begin
                req_g  = In_SEND[i];
                data_g = In_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign fire = (state == XFER) && req_g && Out_RDY;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            grant     <= grant_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        rr_ptr_nx    = rr_ptr;
        grant_nx     = grant;
        burst_cnt_nx = burst_cnt;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nx     = pick;
                    burst_cnt_nx = '0;
                    state_nx     = XFER;
                end
            end
            XFER: begin
                if (fire) begin
                    if (burst_cnt == LAST_CNT) begin
                        // Finished source drops to lowest priority.
                        rr_ptr_nx = (grant == 2'(NUM_SRC - 1)) ? 2'd0
                                                                : grant + 2'd1;
                        state_nx  = IDLE;
                    end else begin
                        burst_cnt_nx = burst_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            In_ACK[i] = fire && (grant == 2'(i));
        end
    end

    assign Out_SEND  = fire;
    assign Out_DATA  = fire ? data_g : '0;
    assign Out_TAG   = fire ? grant : 2'd0;
    assign Out_COUNT = fire ? CNT_W'(1) : '0;
    assign BUSY      = (state == XFER);

endmodule

// File: tb/tb_ll_stream_rr_scheduler.sv
// tb_ll_stream_rr_scheduler: directed and random stimulus for the
// round-robin burst scheduler, checked against a transaction-level model.
module tb_ll_stream_rr_scheduler;

    localparam int NS = 4;
    localparam int DW = 16;
    localparam int BL = 4;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [NS*DW-1:0] In_DATA;
    logic [NS-1:0] In_SEND = '0;
    logic [NS*CW-1:0] In_COUNT = '0;
    logic [NS-1:0] In_ACK;
    logic [DW-1:0] Out_DATA;
    logic          Out_SEND;
    logic [CW-1:0] Out_COUNT;
    logic [1:0]    Out_TAG;
    logic          Out_RDY = 1'b1;
    logic          Out_ACK = 1'b0;
    logic          BUSY;

    always #5 CLK = ~CLK;

    ll_stream_rr_scheduler #(
        .NUM_SRC(NS), .DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .In_DATA(In_DATA), .In_SEND(In_SEND), .In_COUNT(In_COUNT),
        .In_ACK(In_ACK),
        .Out_DATA(Out_DATA), .Out_SEND(Out_SEND), .Out_COUNT(Out_COUNT),
        .Out_TAG(Out_TAG), .Out_RDY(Out_RDY), .Out_ACK(Out_ACK),
        .BUSY(BUSY)
    );

    // Each source presents base + number of tokens already consumed.
    logic [DW-1:0] base [NS];
    logic [DW-1:0] cnt  [NS];

    initial begin
        base[0] = 16'h0A00;
        base[1] = 16'h0B00;
        base[2] = 16'h0010;
        base[3] = 16'h0D00;
        for (int i = 0; i < NS; i++) cnt[i] = '0;
    end

    always @(posedge CLK) begin
        for (int i = 0; i < NS; i++)
            if (In_ACK[i]) cnt[i] <= cnt[i] + 16'd1;
    end

    always_comb begin
        In_DATA = '0;
        for (int i = 0; i < NS; i++)
            In_DATA[i*DW +: DW] = base[i] + cnt[i];
    end

    typedef struct {
        int tag;
        int data;
        int ack;
        int cyc;
    } xfer_t;

    xfer_t log_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    busy_cyc = 0;

    // Transaction-level model: who owns the port, how many tokens it has
    // moved, and which source has first claim at the next arbitration.
    bit    m_busy = 0;
    int    m_own = 0;
    int    m_done = 0;
    int    m_ptr = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            logic [NS-1:0] e_ack;
            logic          e_send;
            logic [DW-1:0] e_data;
            int            e_tag;
            logic          e_busy;
            @(negedge CLK);
            cyc++;
            e_ack  = '0;
            e_send = 1'b0;
            e_data = '0;
            e_tag  = 0;
            e_busy = 1'b0;
            if (RESET) begin
                m_busy = 0;
                m_done = 0;
                m_ptr  = 0;
            end else if (!m_busy) begin
                for (int k = NS - 1; k >= 0; k--) begin
                    if (In_SEND[(m_ptr + k) % NS]) begin
                        m_own = (m_ptr + k) % NS;
                        m_busy = 1;
                    end
                end
                m_done = 0;
            end else begin
                e_busy = 1'b1;
                if (In_SEND[m_own] && Out_RDY) begin
                    e_send = 1'b1;
                    e_ack[m_own] = 1'b1;
                    e_data = In_DATA[m_own*DW +: DW];
                    e_tag  = m_own;
                    m_done++;
                    if (m_done == BL) begin
                        m_busy = 0;
                        m_ptr  = (m_own + 1) % NS;
                    end
                end
            end
            n_vec++;
            if (In_ACK !== e_ack || Out_SEND !== e_send ||
                Out_DATA !== e_data || int'(Out_TAG) != e_tag ||
                Out_COUNT !== CW'(e_send) || BUSY !== e_busy) begin
                n_err++;
                $display("FAIL cycle%0d: got ack=%b send=%b data=%h tag=%0d cnt=%0d busy=%b, expected ack=%b send=%b data=%h tag=%0d cnt=%0d busy=%b",
                         cyc, In_ACK, Out_SEND, Out_DATA, Out_TAG, Out_COUNT,
                         BUSY, e_ack, e_send, e_data, e_tag, e_send, e_busy);
            end
            if (BUSY) busy_cyc++;
            if (Out_SEND)
                log_q.push_back('{int'(Out_TAG), int'(Out_DATA),
                                  int'(In_ACK), cyc});
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_sends(input string name, input int n, input int budget);
        for (int t = 0; t < budget && log_q.size() < n; t++) step(1);
        chk(name, log_q.size() >= n, 1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        log_q.delete();
    endtask

    int c0;
    int b0;

    initial begin
        fork
            monitor();
        join_none

        // Idle after reset: nothing moves for 20 cycles.
        step(2);
        RESET = 1'b0;
        b0 = busy_cyc;
        step(20);
        chk("idle_sends", log_q.size(), 0);
        chk("idle_busy", busy_cyc - b0, 0);

        // Single requester: one decision cycle then four back-to-back tokens.
        c0 = cyc;
        In_SEND = 4'b0100;
        wait_sends("src2_timeout", 4, 20);
        In_SEND = '0;
        if (log_q.size() >= 4) begin
            chk("src2_first_cyc", log_q[0].cyc, c0 + 2);
            for (int k = 0; k < 4; k++) begin
                chk("src2_tag", log_q[k].tag, 2);
                chk("src2_data", log_q[k].data, 16'h0010 + k);
                chk("src2_ack", log_q[k].ack, 4'b0100);
                chk("src2_cyc", log_q[k].cyc, log_q[0].cyc + k);
            end
        end
        step(1);
        chk("src2_busy_drop", BUSY, 0);

        // All sources requesting: 0,1,2,3,0 bursts, one idle gap each.
        do_reset();
        In_SEND = 4'b1111;
        wait_sends("all_timeout", 20, 200);
        In_SEND = '0;
        if (log_q.size() >= 20) begin
            for (int k = 0; k < 20; k++)
                chk("all_tag", log_q[k].tag, (k / 4) % 4);
            chk("all_gap", log_q[4].cyc - log_q[3].cyc, 2);
            chk("all_gap2", log_q[16].cyc - log_q[15].cyc, 2);
        end

        // Downstream stall mid-burst; source 3 waits its turn.
        do_reset();
        In_SEND = 4'b1010;
        wait_sends("stall_timeout_a", 2, 20);
        Out_RDY = 1'b0;
        step(3);
        chk("stall_no_send", log_q.size(), 2);
        Out_RDY = 1'b1;
        wait_sends("stall_timeout_b", 5, 30);
        In_SEND = '0;
        if (log_q.size() >= 5) begin
            for (int k = 0; k < 4; k++) chk("stall_tag", log_q[k].tag, 1);
            chk("stall_gap", log_q[2].cyc - log_q[1].cyc, 4);
            chk("stall_next", log_q[4].tag, 3);
        end

        // Granted source drops its request; grant is held.
        do_reset();
        In_SEND = 4'b0011;
        wait_sends("drop_timeout_a", 2, 20);
        In_SEND = 4'b0010;
        step(3);
        chk("drop_hold", log_q.size(), 2);
        chk("drop_busy", BUSY, 1);
        In_SEND = 4'b0011;
        wait_sends("drop_timeout_b", 5, 30);
        In_SEND = '0;
        if (log_q.size() >= 5) begin
            for (int k = 0; k < 4; k++) chk("drop_tag", log_q[k].tag, 0);
            chk("drop_data", log_q[2].data - log_q[1].data, 1);
            chk("drop_next", log_q[4].tag, 1);
        end

        // Reset mid-burst: immediate abort, restart from source 0.
        do_reset();
        In_SEND = 4'b1000;
        wait_sends("rst_timeout_a", 2, 20);
        RESET = 1'b1;
        #1;
        chk("rst_send", Out_SEND, 0);
        chk("rst_ack", In_ACK, 0);
        chk("rst_busy", BUSY, 0);
        step(2);
        In_SEND = 4'b1001;
        RESET = 1'b0;
        log_q.delete();
        wait_sends("rst_timeout_b", 4, 20);
        In_SEND = '0;
        if (log_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("rst_tag", log_q[k].tag, 0);
        end

        // Random traffic against the model.
        step(6);
        for (int t = 0; t < 800; t++) begin
            In_SEND  = 4'($urandom);
            Out_RDY  = ($urandom_range(0, 3) != 0);
            Out_ACK  = 1'($urandom);
            In_COUNT = {$urandom, $urandom};
            RESET    = ($urandom_range(0, 99) == 0);
            step(1);
        end
        RESET = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
